// File: rtl/inst_encoder.sv
// inst_encoder: packs symbolic Cirno instructions into 9-bit words and writes them sequentially into instruction RAM.
// Optional feature macro: INST_ENCODER_LDI_EN enables the two-word LDI pseudo-op (op 13).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready is high only while IDLE
//   op, ra, rb, imm       symbolic instruction; imm[3:0] carries funct for RTYPE
//   mem_we/addr/wdata     registered instruction RAM write port
//   err                   one-cycle pulse for a rejected request
//   full, halted          sticky until reset
//   word_count            words written since reset
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        ra,
  input  logic [1:0]        rb,
  input  logic [7:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8:0]        mem_wdata,
  output logic              err,
  output logic              full,
  output logic              halted,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, EMIT2, FULL, HALTED} state_t;
  state_t r_state, w_next;
  logic w_acc, w_legal, w_last, w_we, w_emit2, w_ldi;
  logic [8:0] w_enc, w_wdata;
  assign in_ready = r_state == IDLE;
  assign full     = r_state == FULL;
  assign halted   = r_state == HALTED;
  assign w_acc    = in_valid && in_ready;
  // The next write lands on the last address exactly when the low bits of the count are all ones.
  assign w_last   = &word_count[ADDR_W-1:0];
  assign w_we     = w_emit2 || (w_acc && w_legal);
  always_comb begin
    w_enc   = 9'h000;
    w_legal = 1'b1;
    case (op)
      4'd1:  w_enc = 9'h001;
      4'd2:  w_enc = {7'b0000011, ra};
      4'd3:  w_enc = {7'b0000010, ra};
      4'd4:  w_enc = {7'b0000001, ra};
      4'd5:  begin w_enc = {5'b01011, imm[3:0]};     w_legal = imm[7:4] == 4'd0; end
      4'd6:  begin w_enc = {3'b111, imm[5:0]};       w_legal = imm[7:6] == 2'd0; end
      4'd7:  begin w_enc = {3'b101, ra, imm[3:0]};   w_legal = imm[7:4] == 4'd0; end
      4'd8:  begin w_enc = {3'b100, ra, imm[3:0]};   w_legal = imm[7:4] == 4'd0; end
      4'd9:  begin w_enc = {3'b110, ra, imm[3:0]};   w_legal = imm[7:4] == 4'd0; end
      4'd10: begin w_enc = {4'b0110, ra, imm[2:0]};  w_legal = imm[7:3] == 5'd0; end
      4'd11: begin w_enc = {4'b0111, ra, imm[2:0]};  w_legal = imm[7:3] == 5'd0; end
      // Funct 0000, 1011 and 11xx would collide with other opcode spaces.
      4'd12: begin w_enc = {1'b0, imm[3:0], ra, rb}; w_legal = imm[3:0] != 4'd0 && imm[3:0] <= 4'd10; end
`ifdef INST_ENCODER_LDI_EN
      // LDI needs two free words; only one is left when the next address is the last one.
      4'd13: begin w_enc = {3'b101, ra, imm[7:4]};   w_legal = !w_last; end
`endif
      4'd0:    w_enc = 9'h000;
      default: w_legal = 1'b0;
    endcase
  end
`ifdef INST_ENCODER_LDI_EN
  logic [8:0] r_lo;
  assign w_emit2 = r_state == EMIT2;
  assign w_ldi   = op == 4'd13;
  assign w_wdata = w_emit2 ? r_lo : w_enc;
  always_ff @(posedge clk) begin
    if (reset) r_lo <= '0;
    else if (w_acc) r_lo <= {3'b100, ra, imm[3:0]};
  end
`else
  assign w_emit2 = 1'b0;
  assign w_ldi   = 1'b0;
  assign w_wdata = w_enc;
`endif
  always_comb begin
    w_next = r_state;
    if (w_emit2) w_next = w_last ? FULL : IDLE;
    else if (w_acc && w_legal) w_next = op == 4'd1 ? HALTED : w_ldi ? EMIT2 : w_last ? FULL : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      r_state <= w_next;
      mem_we  <= w_we;
      err     <= w_acc && !w_legal;
      if (w_we) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= w_wdata;
        word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: checks inst_encoder (ADDR_W=8 and ADDR_W=2 instances) against vectors and an arithmetic reference model.
module tb_inst_encoder;
`ifdef INST_ENCODER_LDI_EN
  localparam bit LDI_EN = 1'b1;
`else
  localparam bit LDI_EN = 1'b0;
`endif
  logic clk, reset, in_valid;
  logic [3:0] op;
  logic [1:0] ra, rb;
  logic [7:0] imm;
  logic we0, err0, full0, halt0, rdy0, we1, err1, full1, halt1, rdy1;
  logic [7:0] addr0;
  logic [1:0] addr1;
  logic [8:0] data0, data1, wc0;
  logic [2:0] wc1;
  inst_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .op(op), .ra(ra), .rb(rb), .imm(imm),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(data0), .err(err0), .full(full0), .halted(halt0), .word_count(wc0));
  inst_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .op(op), .ra(ra), .rb(rb), .imm(imm),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(data1), .err(err1), .full(full1), .halted(halt1), .word_count(wc1));
  int o_we[2], o_addr[2], o_data[2], o_err[2], o_full[2], o_halt[2], o_rdy[2], o_wc[2];
  always_comb begin
    o_we[0] = int'(we0);     o_we[1] = int'(we1);
    o_addr[0] = int'(addr0); o_addr[1] = int'(addr1);
    o_data[0] = int'(data0); o_data[1] = int'(data1);
    o_err[0] = int'(err0);   o_err[1] = int'(err1);
    o_full[0] = int'(full0); o_full[1] = int'(full1);
    o_halt[0] = int'(halt0); o_halt[1] = int'(halt1);
    o_rdy[0] = int'(rdy0);   o_rdy[1] = int'(rdy1);
    o_wc[0] = int'(wc0);     o_wc[1] = int'(wc1);
  end
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  int n_chk = 0, n_fail = 0;
  int m_cnt[2], m_pw[2], e_addr[2], e_data[2];
  bit m_full[2], m_halt[2], m_pend[2], e_we[2], e_err[2];
  int depth[2] = '{256, 4};
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void ref_enc(input int o, input int a, input int b, input int im, input int cnt, input int dep,
                                  output bit ok, output int n, output int w0, output int w1);
    ok = 1'b1; n = 1; w0 = 0; w1 = 0;
    case (o)
      0: w0 = 0;
      1: w0 = 1;
      2: w0 = 12 + a;
      3: w0 = 8 + a;
      4: w0 = 4 + a;
      5: begin ok = im < 16; w0 = 176 + im; end
      6: begin ok = im < 64; w0 = 448 + im; end
      7: begin ok = im < 16; w0 = 320 + 16 * a + im; end
      8: begin ok = im < 16; w0 = 256 + 16 * a + im; end
      9: begin ok = im < 16; w0 = 384 + 16 * a + im; end
      10: begin ok = im < 8; w0 = 192 + 8 * a + im; end
      11: begin ok = im < 8; w0 = 224 + 8 * a + im; end
      12: begin ok = (im % 16) >= 1 && (im % 16) <= 10; w0 = 16 * (im % 16) + 4 * a + b; end
      13: begin ok = LDI_EN && (dep - cnt) >= 2; n = 2; w0 = 320 + 16 * a + im / 16; w1 = 256 + 16 * a + im % 16; end
      default: ok = 1'b0;
    endcase
  endfunction
  task automatic model(input int k, input bit rs, input bit v, input int o, input int a, input int b, input int im);
    bit ok;
    int n, w0, w1;
    if (rs) begin
      m_cnt[k] = 0; m_full[k] = 0; m_halt[k] = 0; m_pend[k] = 0;
      e_we[k] = 0; e_err[k] = 0; e_addr[k] = 0; e_data[k] = 0;
      return;
    end
    e_we[k] = 0; e_err[k] = 0;
    if (m_pend[k]) begin
      e_we[k] = 1; e_addr[k] = m_cnt[k]; e_data[k] = m_pw[k]; m_cnt[k]++; m_pend[k] = 0;
      if (m_cnt[k] == depth[k]) m_full[k] = 1;
    end else if (v && !m_full[k] && !m_halt[k]) begin
      ref_enc(o, a, b, im, m_cnt[k], depth[k], ok, n, w0, w1);
      if (!ok) e_err[k] = 1;
      else begin
        e_we[k] = 1; e_addr[k] = m_cnt[k]; e_data[k] = w0; m_cnt[k]++;
        if (n == 2) begin m_pend[k] = 1; m_pw[k] = w1; end
        else if (o == 1) m_halt[k] = 1;
        else if (m_cnt[k] == depth[k]) m_full[k] = 1;
      end
    end
  endtask
  task automatic step(input bit rs, input bit v, input int o, input int a, input int b, input int im);
    reset = rs; in_valid = v; op = o[3:0]; ra = a[1:0]; rb = b[1:0]; imm = im[7:0];
    for (int k = 0; k < 2; k++) model(k, rs, v, o, a, b, im);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("we%0d", k), o_we[k], int'(e_we[k]));
      chk($sformatf("addr%0d", k), o_addr[k], e_addr[k]);
      chk($sformatf("data%0d", k), o_data[k], e_data[k]);
      chk($sformatf("err%0d", k), o_err[k], int'(e_err[k]));
      chk($sformatf("full%0d", k), o_full[k], int'(m_full[k]));
      chk($sformatf("halted%0d", k), o_halt[k], int'(m_halt[k]));
      chk($sformatf("ready%0d", k), o_rdy[k], int'(!m_full[k] && !m_halt[k] && !m_pend[k]));
      chk($sformatf("count%0d", k), o_wc[k], m_cnt[k]);
    end
  endtask
  typedef struct { int o, a, b, im; bit we, err; int data; } vec_t;
  vec_t tbl[18];
  initial begin
    int o, im;
    reset = 1'b1; in_valid = 1'b0; op = '0; ra = '0; rb = '0; imm = '0;
    tbl[0]  = '{7, 2, 0, 'h0A, 1, 0, 'h16A};
    tbl[1]  = '{11, 1, 0, 5, 1, 0, 'h0ED};
    tbl[2]  = '{12, 3, 0, 9, 1, 0, 'h09C};
    tbl[3]  = '{6, 0, 0, 'h2A, 1, 0, 'h1EA};
    tbl[4]  = '{9, 0, 0, 'h13, 0, 1, 0};
    tbl[5]  = '{12, 1, 1, 'h0B, 0, 1, 0};
    tbl[6]  = '{12, 1, 1, 'h00, 0, 1, 0};
    tbl[7]  = '{14, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{15, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{2, 3, 0, 0, 1, 0, 'h00F};
    tbl[10] = '{5, 0, 0, 'h0F, 1, 0, 'h0BF};
    tbl[11] = '{10, 2, 0, 7, 1, 0, 'h0D7};
    tbl[12] = '{12, 1, 2, 'h0A, 1, 0, 'h0A6};
    tbl[13] = '{3, 1, 0, 0, 1, 0, 'h009};
    tbl[14] = '{4, 2, 0, 0, 1, 0, 'h006};
    tbl[15] = '{0, 0, 0, 0, 1, 0, 'h000};
    tbl[16] = '{8, 3, 0, 5, 1, 0, 'h135};
    tbl[17] = '{8, 3, 0, 'h10, 0, 1, 0};
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_ready", o_rdy[0], 1);
    chk("reset_count", o_wc[0], 0);
    for (int i = 0; i < 18; i++) begin
      step(0, 1, tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].im);
      chk($sformatf("tbl%0d_we", i), o_we[0], int'(tbl[i].we));
      chk($sformatf("tbl%0d_err", i), o_err[0], int'(tbl[i].err));
      if (tbl[i].we) chk($sformatf("tbl%0d_data", i), o_data[0], tbl[i].data);
      if (i == 2) chk("three_count", o_wc[0], 3);
    end
    // LDI expansion or rejection
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 13, 1, 0, 'hC5);
    if (LDI_EN) begin
      chk("ldi_hi_we", o_we[0], 1); chk("ldi_hi_data", o_data[0], 'h15C); chk("ldi_hi_addr", o_addr[0], 0);
      chk("ldi_busy", o_rdy[0], 0);
      step(0, 1, 0, 0, 0, 0);
      chk("ldi_lo_we", o_we[0], 1); chk("ldi_lo_data", o_data[0], 'h115); chk("ldi_lo_addr", o_addr[0], 1);
    end else begin
      chk("ldi_off_err", o_err[0], 1); chk("ldi_off_we", o_we[0], 0);
      step(0, 0, 0, 0, 0, 0);
      chk("ldi_off_count", o_wc[0], 0);
    end
    // HALT locks out further requests
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("halt_data", o_data[0], 1); chk("halt_flag", o_halt[0], 1); chk("halt_ready", o_rdy[0], 0);
    step(0, 1, 2, 1, 0, 0);
    chk("halt_ignore_we", o_we[0], 0); chk("halt_ignore_count", o_wc[0], 1);
    // Small memory fills after four words
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    chk("full_flag", o_full[1], 1); chk("full_ready", o_rdy[1], 0);
    step(0, 1, 0, 0, 0, 0);
    chk("full_no_we", o_we[1], 0); chk("full_count", o_wc[1], 4);
    // LDI with a single free word is rejected
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 13, 2, 0, 'h37);
    chk("cap_err", o_err[1], 1); chk("cap_no_we", o_we[1], 0);
    step(0, 0, 0, 0, 0, 0);
    // Reset right after LDI acceptance drops the second word
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 13, 1, 0, 'hC5);
    step(1, 0, 0, 0, 0, 0);
    chk("drop_we", o_we[0], 0); chk("drop_count", o_wc[0], 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_no_lo", o_we[0], 0);
    // Randomized traffic against the model
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      o = $urandom_range(0, 15);
      if (o == 1 && $urandom_range(0, 7) != 0) o = 0;
      im = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      if ((m_halt[0] || m_full[0]) && $urandom_range(0, 3) == 0) step(1, 0, 0, 0, 0, 0);
      else if ($urandom_range(0, 60) == 0) step(1, 1, o, 0, 0, im);
      else step(0, $urandom_range(0, 3) != 0, o, $urandom_range(0, 3), $urandom_range(0, 3), im);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Hardware instruction encoder and program loader for the 9-bit Cirno ISA: the write side that produces the words the `decoder` consumes. It accepts one symbolic instruction per handshake (op id, register fields, immediate), range-checks it, and packs it into the exact 9-bit encoding the `decoder` expects. It then writes the word sequentially into instruction memory. It sits between the host/boot interface and instruction RAM and is used to load programs before the core runs.

## Interface
- `ADDR_W`, 8: instruction memory address width; capacity `DEPTH = 2**ADDR_W` words.
- `clk`  input  1  single clock, all state on posedge.
- `reset`  input  1  synchronous, active-high.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  encoder can accept; `(state==IDLE)`.
- `op`  input  4  op id: 0 NOP, 1 HALT, 2 INCR, 3 JMP, 4 BEQ, 5 BEQI, 6 JMPI, 7 MOVHI, 8 MOVLI, 9 ANDI, 10 SHLI, 11 SHRI, 12 RTYPE, 13 LDI, 14-15 illegal.
- `ra`  input  2  first register (r1).
- `rb`  input  2  second register (r2; RTYPE only).
- `imm`  input  8  immediate; for RTYPE, `imm[3:0]` is funct.
- `mem_we`  output  1  write strobe to instruction RAM.
- `mem_addr`  output  ADDR_W  write address.
- `mem_wdata`  output  9  encoded instruction.
- `err`  output  1  one-cycle pulse: request rejected, nothing written.
- `full`  output  1  memory filled.
- `halted`  output  1  HALT word written.
- `word_count`  output  ADDR_W+1  words written since reset.

## Operation
Encodings use bit 8 as MSB:
- NOP `000000000`; HALT `000000001`; INCR `0000011rr`; JMP `0000010rr`; BEQ `0000001rr`.
- BEQI `01011iiii`; JMPI `111iiiiii`; MOVHI `101rriiii`; MOVLI `100rriiii`; ANDI `110rriiii`.
- SHLI `0110rriii`; SHRI `0111rriii`.
- RTYPE `0ffffxxyy`, with x=ra and y=rb.

Legality:
- Immediate bits above the field width (4, 6, 4, 4, 4, 3, 3 respectively) must be zero. Otherwise the request is rejected.
- Legal RTYPE funct values: 0001-0110, 0111 (mv), 1000 (load), 1001 (store), 1010.
- Funct 0000, 1011 and 11xx alias other opcodes and are rejected.
- Op 14/15 are rejected.

LDI is a pseudo-op that emits two words:
- First MOVHI `ra, imm[7:4]`.
- Then MOVLI `ra, imm[3:0]`.

FSM:
- IDLE: accept on `in_valid && in_ready`.
  - Illegal request: `err`=1 for the next cycle, stay IDLE.
  - Legal single-word request: write, then go to HALTED if the op is HALT, FULL if the address just written is `DEPTH-1`, else stay IDLE.
  - Legal LDI: write MOVHI, go to EMIT2.
- EMIT2: write MOVLI at the next address, then go to FULL or IDLE.
- FULL: `full`=1; `in_ready`=0 until reset.
- HALTED: `halted`=1; `in_ready`=0 until reset.

Capacity: LDI accepted with fewer than 2 free words produces `err` and no write.

Address: `mem_addr` equals `word_count[ADDR_W-1:0]` at write time. `word_count` increments on every `mem_we`.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0, `full`=0, `halted`=0, `word_count`=0, state IDLE (`in_ready`=1).
- Write latency 1 cycle: a request accepted at edge N drives `mem_we`/`mem_addr`/`mem_wdata` registered during cycle N+1 (one cycle only).
- LDI: `mem_we` high in cycles N+1 and N+2 at consecutive addresses; `in_ready` low in cycle N+1.
- Back-to-back single-word requests sustain one write per cycle.
- `err` is high only in cycle N+1; no other output changes for a rejected request.
- Reset asserted in any state, including EMIT2: return to reset values at that edge. A pending MOVLI is dropped.
- Inputs are sampled only on the accepting edge; they may change freely otherwise.

## Configuration
- `INST_ENCODER_LDI_EN` defined: op 13 expands as above, with EMIT2 state and the 2-word capacity check.
- `INST_ENCODER_LDI_EN` undefined: op 13 is illegal (`err`, no write); EMIT2 logic is absent.

## Test plan
- Reset, then MOVHI ra=2 imm=0xA, then SHRI ra=1 imm=5, then RTYPE funct=9 ra=3 rb=0 on three consecutive cycles -> writes 0x16A @0, 0x0ED @1, 0x09C @2 on consecutive cycles; `word_count`=3.
- JMPI imm=0x2A -> 0x1EA. ANDI imm=0x13 -> `err` pulse, no write. RTYPE funct=0xB -> `err`, no write; `word_count` unchanged.
- LDI ra=1 imm=0xC5 (macro on) -> 0x15C then 0x115 at consecutive addresses, `in_ready` low one cycle. With the macro off -> `err`, no write.
- HALT -> 0x001 written, `halted`=1, `in_ready`=0. Further `in_valid` is ignored until reset.
- ADDR_W=2: four NOPs -> `full`=1 after the 4th write, 5th not accepted. With 3 words written, LDI -> `err`.
- Reset asserted in the cycle after LDI acceptance -> only MOVHI observed (if its write was already registered), no MOVLI; `word_count`=0 afterwards.
